// File: rtl/sdram_rd_pkg.sv
// Shared definitions for the SDRAM read-side burst scheduler.
//   state_t  : scheduler FSM states
//   LEN_W    : width of the burst-length field (lengths 1..256)
//   min_len  : clamps the nominal burst length to the words left in a frame
package sdram_rd_pkg;

  localparam int unsigned LEN_W = 9;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CHECK,
    ST_REQ,
    ST_XFER
  } state_t;

  function automatic logic [LEN_W-1:0] min_len(input int unsigned burst,
                                                input int unsigned remain);
    int unsigned m;
    m = (remain < burst) ? remain : burst;
    return LEN_W'(m);
  endfunction

endpackage

// File: rtl/sdram_rd_burst_ctrl_if.sv
// Read channel between the burst scheduler and the SDRAM controller.
//   rd_req        : burst request (scheduler -> controller)
//   rd_addr       : burst start word address
//   rd_len        : burst length in words, 1..256
//   rd_ack        : controller accepted the request
//   rd_data_valid : a returned word is on the data bus this cycle
//   rd_done       : last word of the burst returned
// master = scheduler side, slave = controller side.
interface sdram_rd_burst_ctrl_if #(
  parameter int unsigned ADDR_W = 22
);
  import sdram_rd_pkg::*;

  logic              rd_req;
  logic [ADDR_W-1:0] rd_addr;
  logic [LEN_W-1:0]  rd_len;
  logic              rd_ack;
  logic              rd_data_valid;
  logic              rd_done;

  modport master (
    output rd_req, rd_addr, rd_len,
    input  rd_ack, rd_data_valid, rd_done
  );

  modport slave (
    input  rd_req, rd_addr, rd_len,
    output rd_ack, rd_data_valid, rd_done
  );

endinterface

// File: rtl/sdram_addr_walker.sv
// Frame address walker: tracks the start address of the next burst and the
// number of words left in the frame, and derives the burst length.
//   clk, rst   : clock, asynchronous active-high reset
//   advance    : a burst of rd_len words completed; step forward
//   restart    : return to the start of the frame (has priority)
//   rd_addr    : next burst start address
//   rd_len     : min(BURST_LEN, words remaining)
//   frame_done : one-cycle pulse when the final burst of a frame completes
module sdram_addr_walker
  import sdram_rd_pkg::*;
#(
  parameter int unsigned ADDR_W      = 22,
  parameter int unsigned BASE_ADDR   = 0,
  parameter int unsigned FRAME_WORDS = 307200,
  parameter int unsigned BURST_LEN   = 256
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              advance,
  input  logic              restart,
  output logic [ADDR_W-1:0] rd_addr,
  output logic [LEN_W-1:0]  rd_len,
  output logic              frame_done
);

  localparam int unsigned       REM_W = $clog2(FRAME_WORDS + 1);
  localparam logic [ADDR_W-1:0] BASE  = ADDR_W'(BASE_ADDR);
  localparam logic [REM_W-1:0]  FRAME = REM_W'(FRAME_WORDS);

  logic [REM_W-1:0] remain;
  logic             last;

  always_comb begin
    rd_len = min_len(BURST_LEN, 32'(remain));
    last   = (32'(remain) == 32'(rd_len));
  end

  // The wrap is folded into the advance itself so that rd_addr never
  // presents a past-the-end address, even for a single cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_addr    <= BASE;
      remain     <= FRAME;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      if (restart) begin
        rd_addr <= BASE;
        remain  <= FRAME;
      end else if (advance) begin
        if (last) begin
          rd_addr    <= BASE;
          remain     <= FRAME;
          frame_done <= 1'b1;
        end else begin
          rd_addr <= rd_addr + ADDR_W'(rd_len);
          remain  <= remain - REM_W'(rd_len);
        end
      end
    end
  end

endmodule

// File: rtl/sdram_rd_burst_ctrl.sv
// Read-side burst scheduler for the SDRAM frame path. Keeps the SDRAM read
// FIFO topped up by issuing fixed-length read bursts over a linear frame
// region (with wrap-around) and forwards returned words to the FIFO.
//   clk, rst         : FIFO write clock, asynchronous active-high reset
//   enable           : permits new bursts
//   frame_sync       : one-cycle pulse, restart at the frame base
//   fifo_wrusedw     : FIFO write-side fill count
//   fifo_full        : FIFO full flag
//   fifo_wr_rst_done : FIFO write side is out of reset
//   rd               : SDRAM controller read channel (master side)
//   fifo_we          : FIFO write enable (data wired straight from SDRAM)
//   busy             : scheduler not idle
//   frame_done       : pulse after the last burst of a frame
//   ovf_err          : sticky, a write was issued while the FIFO was full
module sdram_rd_burst_ctrl
  import sdram_rd_pkg::*;
#(
  parameter int unsigned ADDR_W      = 22,
  parameter int unsigned BASE_ADDR   = 0,
  parameter int unsigned FRAME_WORDS = 307200,
  parameter int unsigned BURST_LEN   = 256,
  parameter int unsigned FIFO_DEPTH  = 512,
  parameter int unsigned USEDW_W     = 10
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               enable,
  input  logic               frame_sync,
  input  logic [USEDW_W-1:0] fifo_wrusedw,
  input  logic               fifo_full,
  input  logic               fifo_wr_rst_done,
  sdram_rd_burst_ctrl_if.master rd,
  output logic               fifo_we,
  output logic               busy,
  output logic               frame_done,
  output logic               ovf_err
);

  // Two words of headroom cover the FIFO's write-side count latency.
  localparam logic [USEDW_W:0] LIMIT = (USEDW_W+1)'(FIFO_DEPTH - 2);

  state_t           state, state_nxt;
  logic             drop;
  logic [LEN_W-1:0] word_cnt;
  logic [USEDW_W:0] level_sum;
  logic             fits;
  logic             kill;
  logic             xfer_end;
  logic             advance;
  logic             restart;

  always_comb begin
    level_sum = {1'b0, fifo_wrusedw} + (USEDW_W+1)'(rd.rd_len);
    fits      = (level_sum <= LIMIT);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (enable && fifo_wr_rst_done) state_nxt = ST_CHECK;
      ST_CHECK: begin
        if (!enable || !fifo_wr_rst_done) state_nxt = ST_IDLE;
        else if (fits)                    state_nxt = ST_REQ;
      end
      ST_REQ:   if (rd.rd_ack)  state_nxt = ST_XFER;
      ST_XFER:  if (rd.rd_done) state_nxt = ST_CHECK;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // A burst is discarded when the frame restarts or the FIFO write side
  // drops out of reset once the controller owns it. A frame_sync that
  // coincides with the ack is treated as arriving mid-burst: the controller
  // has already latched the old address, so the burst is discarded too.
  always_comb begin
    kill = ((state == ST_XFER) && (frame_sync || !fifo_wr_rst_done)) ||
           ((state == ST_REQ) && (!fifo_wr_rst_done || (frame_sync && rd.rd_ack)));
    xfer_end = (state == ST_XFER) && rd.rd_done;
    restart  = (frame_sync && (state != ST_XFER)) || (xfer_end && (drop || kill));
    advance  = xfer_end && !drop && !kill;
  end

  always_comb begin
    rd.rd_req = (state == ST_REQ);
    busy      = (state != ST_IDLE);
    // word_cnt also stops writes if the controller returns surplus words.
    fifo_we   = (state == ST_XFER) && rd.rd_data_valid && !drop &&
                (word_cnt < rd.rd_len);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      drop <= 1'b0;
    end else if (xfer_end) begin
      drop <= 1'b0;
    end else if (kill) begin
      drop <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      word_cnt <= '0;
    end else if (state == ST_REQ) begin
      word_cnt <= '0;
    end else if ((state == ST_XFER) && rd.rd_data_valid && (word_cnt != '1)) begin
      word_cnt <= word_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf_err <= 1'b0;
    end else if (fifo_we && fifo_full) begin
      ovf_err <= 1'b1;
    end
  end

  sdram_addr_walker #(
    .ADDR_W      (ADDR_W),
    .BASE_ADDR   (BASE_ADDR),
    .FRAME_WORDS (FRAME_WORDS),
    .BURST_LEN   (BURST_LEN)
  ) u_walker (
    .clk        (clk),
    .rst        (rst),
    .advance    (advance),
    .restart    (restart),
    .rd_addr    (rd.rd_addr),
    .rd_len     (rd.rd_len),
    .frame_done (frame_done)
  );

endmodule

// File: tb/tb_sdram_rd_burst_ctrl.sv
// Self-checking bench for sdram_rd_burst_ctrl. Emulates the SDRAM controller
// read channel and predicts addresses, lengths, write counts and frame_done
// from a frame-offset model.
module tb_sdram_rd_burst_ctrl;

  localparam int unsigned BASE  = 'h2000;
  localparam int unsigned FRAME = 1000;
  localparam int unsigned BURST = 256;

  logic       clk;
  logic       rst;
  logic       enable;
  logic       frame_sync;
  logic [9:0] fifo_wrusedw;
  logic       fifo_full;
  logic       fifo_wr_rst_done;
  logic       fifo_we;
  logic       busy;
  logic       frame_done;
  logic       ovf_err;

  sdram_rd_burst_ctrl_if #(.ADDR_W(22)) rdi ();

  sdram_rd_burst_ctrl #(
    .ADDR_W      (22),
    .BASE_ADDR   (BASE),
    .FRAME_WORDS (FRAME),
    .BURST_LEN   (BURST),
    .FIFO_DEPTH  (512),
    .USEDW_W     (10)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .enable           (enable),
    .frame_sync       (frame_sync),
    .fifo_wrusedw     (fifo_wrusedw),
    .fifo_full        (fifo_full),
    .fifo_wr_rst_done (fifo_wr_rst_done),
    .rd               (rdi),
    .fifo_we          (fifo_we),
    .busy             (busy),
    .frame_done       (frame_done),
    .ovf_err          (ovf_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          checks   = 0;
  int          failures = 0;
  int unsigned off      = 0;   // model: word offset of next burst in frame
  int          fd_model = 0;
  int          fd_total = 0;

  always @(negedge clk) if (frame_done) fd_total++;

  typedef struct {
    logic [9:0] usedw;
    logic       exp_req;
  } thresh_vec_t;

  thresh_vec_t tvec [7];

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  // Sample/drive point: 2 time units after the rising edge.
  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  function automatic int unsigned exp_len();
    return (FRAME - off < BURST) ? FRAME - off : BURST;
  endfunction

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_rd_req"},     rdi.rd_req, 0);
    chk({tag, "_rd_addr"},    rdi.rd_addr, BASE);
    chk({tag, "_rd_len"},     rdi.rd_len, BURST);
    chk({tag, "_fifo_we"},    fifo_we, 0);
    chk({tag, "_busy"},       busy, 0);
    chk({tag, "_frame_done"}, frame_done, 0);
    chk({tag, "_ovf_err"},    ovf_err, 0);
  endtask

  // One complete burst as seen by the controller.
  //   sync_at  : word index before which the burst is killed (-1 = never)
  //   mode     : 0 = kill by frame_sync, 1 = kill by FIFO write-side reset
  //   req_sync : pulse frame_sync while the request is pending
  //   full_at  : word index presented with fifo_full high (-1 = never)
  task automatic run_burst(input int sync_at, input int mode,
                           input bit req_sync, input int full_at);
    int          wait_c;
    int          sent;
    int          we_cnt;
    int          d;
    int unsigned len_e;
    int unsigned addr_e;
    bit          dropping;
    bit          fd_exp;

    wait_c = 0;
    while (!rdi.rd_req && wait_c < 60) begin
      cyc();
      wait_c++;
    end
    if (!rdi.rd_req) begin
      chk("req_timeout", rdi.rd_req, 1);
      return;
    end

    len_e  = exp_len();
    addr_e = BASE + off;
    if (req_sync) begin
      frame_sync = 1'b1;
      cyc();
      frame_sync = 1'b0;
      off    = 0;
      len_e  = exp_len();
      addr_e = BASE;
      chk("sync_req_still_high", rdi.rd_req, 1);
    end
    chk("rd_addr", rdi.rd_addr, addr_e);
    chk("rd_len", rdi.rd_len, len_e);

    d = int'($urandom_range(0, 3));
    for (int k = 0; k < d; k++) begin
      cyc();
      chk("req_hold", rdi.rd_req, 1);
      chk("addr_stable", rdi.rd_addr, addr_e);
    end

    rdi.rd_ack = 1'b1;
    cyc();
    rdi.rd_ack = 1'b0;
    chk("req_drop_after_ack", rdi.rd_req, 0);

    sent = 0;
    we_cnt = 0;
    dropping = 1'b0;
    while (sent < int'(len_e)) begin
      if (!dropping && sync_at == sent) begin
        if (mode == 0) frame_sync = 1'b1;
        else           fifo_wr_rst_done = 1'b0;
        dropping = 1'b1;
        cyc();
        frame_sync = 1'b0;
      end
      if ($urandom_range(0, 3) == 0) cyc();
      rdi.rd_data_valid = 1'b1;
      rdi.rd_done       = (sent == int'(len_e) - 1);
      fifo_full         = (sent == full_at);
      #1;
      if (fifo_we) we_cnt++;
      sent++;
      cyc();
      rdi.rd_data_valid = 1'b0;
      rdi.rd_done       = 1'b0;
      fifo_full         = 1'b0;
    end

    chk("we_count", we_cnt, dropping ? sync_at : int'(len_e));
    fd_exp = !dropping && (off + len_e == FRAME);
    chk("frame_done", frame_done, fd_exp);
    if (fd_exp) fd_model++;
    if (dropping) off = 0;
    else begin
      off = off + len_e;
      if (off == FRAME) off = 0;
    end
    chk("next_addr", rdi.rd_addr, BASE + off);
  endtask

  initial begin
    #(10_000_000);
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    tvec[0] = '{usedw: 10'd0,    exp_req: 1'b1};
    tvec[1] = '{usedw: 10'd255,  exp_req: 1'b0};
    tvec[2] = '{usedw: 10'd254,  exp_req: 1'b1};
    tvec[3] = '{usedw: 10'd511,  exp_req: 1'b0};
    tvec[4] = '{usedw: 10'd1023, exp_req: 1'b0};
    tvec[5] = '{usedw: 10'd300,  exp_req: 1'b0};
    tvec[6] = '{usedw: 10'd100,  exp_req: 1'b1};

    rst = 1'b1;
    enable = 1'b0;
    frame_sync = 1'b0;
    fifo_wrusedw = 10'd1023;
    fifo_full = 1'b0;
    fifo_wr_rst_done = 1'b1;
    rdi.rd_ack = 1'b0;
    rdi.rd_data_valid = 1'b0;
    rdi.rd_done = 1'b0;

    cyc();
    cyc();
    chk_reset_vals("in_reset");
    rst = 1'b0;
    cyc();
    chk_reset_vals("after_reset");

    // Threshold table, evaluated in CHECK with a full-length burst pending.
    enable = 1'b1;
    cyc();
    chk("busy_in_check", busy, 1);
    for (int i = 0; i < 7; i++) begin
      fifo_wrusedw = tvec[i].usedw;
      cyc();
      chk($sformatf("thresh_%0d", tvec[i].usedw), rdi.rd_req, tvec[i].exp_req);
      fifo_wrusedw = 10'd1023;
      if (rdi.rd_req) run_burst(0, 0, 1'b0, -1);
    end

    // Backpressure held at 255, released to 254.
    for (int i = 0; i < 6; i++) begin
      fifo_wrusedw = 10'd255;
      cyc();
      chk("bp_255_no_req", rdi.rd_req, 0);
    end
    fifo_wrusedw = 10'd254;
    chk("bp_254_same_cycle", rdi.rd_req, 0);
    cyc();
    chk("bp_254_next_cycle", rdi.rd_req, 1);
    fifo_wrusedw = 10'd0;
    run_burst(-1, 0, 1'b0, -1);

    // Rest of the frame (tail burst) and wrap to the next frame.
    for (int b = 0; b < 4; b++) run_burst(-1, 0, 1'b0, -1);

    // frame_sync while waiting in CHECK.
    fifo_wrusedw = 10'd1023;
    cyc();
    chk("hold_in_check", rdi.rd_req, 0);
    frame_sync = 1'b1;
    cyc();
    frame_sync = 1'b0;
    off = 0;
    chk("sync_check_addr", rdi.rd_addr, BASE);
    chk("sync_check_len", rdi.rd_len, BURST);
    fifo_wrusedw = 10'd0;

    // frame_sync mid-XFER after 100 words, then frame_sync during REQ.
    run_burst(-1, 0, 1'b0, -1);
    run_burst(100, 0, 1'b0, -1);
    run_burst(-1, 0, 1'b0, -1);
    run_burst(-1, 0, 1'b1, -1);

    // enable dropped while a request is pending.
    cyc();
    chk("req_before_disable", rdi.rd_req, 1);
    enable = 1'b0;
    run_burst(-1, 0, 1'b0, -1);
    cyc();
    chk("idle_after_disable", busy, 0);
    for (int i = 0; i < 4; i++) begin
      cyc();
      chk("no_req_disabled", rdi.rd_req, 0);
    end
    enable = 1'b1;

    // FIFO write side falls back into reset mid-burst.
    cyc();
    run_burst(50, 1, 1'b0, -1);
    cyc();
    chk("idle_wr_rst", busy, 0);
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("stay_idle_wr_rst", busy, 0);
    end
    fifo_wr_rst_done = 1'b1;

    // Overflow is sticky.
    chk("ovf_before", ovf_err, 0);
    run_burst(-1, 0, 1'b0, 10);
    chk("ovf_set", ovf_err, 1);

    // Randomized traffic against the offset model.
    for (int r = 0; r < 15; r++) begin
      int unsigned v;
      int          sa;
      bit          rs;
      v = $urandom_range(0, 1023);
      fifo_wrusedw = 10'(v);
      cyc();
      chk("rand_thresh", rdi.rd_req, (v + exp_len() <= 510));
      if (!rdi.rd_req) fifo_wrusedw = 10'($urandom_range(0, 510 - exp_len()));
      sa = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, exp_len() - 1)) : -1;
      rs = ($urandom_range(0, 5) == 0);
      run_burst(sa, 0, rs, -1);
    end
    chk("ovf_sticky", ovf_err, 1);

    // Asynchronous reset while a request is pending.
    fifo_wrusedw = 10'd0;
    cyc();
    chk("req_before_reset", rdi.rd_req, 1);
    rst = 1'b1;
    #1;
    chk_reset_vals("async_reset");
    off = 0;
    cyc();
    rst = 1'b0;
    cyc();
    run_burst(-1, 0, 1'b0, -1);

    chk("frame_done_total", fd_total, fd_model);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sdram_rd_burst_ctrl.md
# sdram_rd_burst_ctrl

Read-side burst scheduler for the SDRAM frame path. Monitors the fill level of the SDRAM read FIFO and issues fixed-length read bursts to the SDRAM controller to keep it topped up. Walks a linear frame region with wrap-around and forwards returned words into the FIFO write port. Runs in the FIFO write-clock domain, between the SDRAM controller's read channel and `Sdram_RD_FIFO`.

## Interface
Parameters:
- `ADDR_W`, 22: SDRAM word-address width.
- `BASE_ADDR`, 0: first word address of the frame region.
- `FRAME_WORDS`, 307200: words per frame; must be ≥ 1.
- `BURST_LEN`, 256: maximum words per burst, 1..256.
- `FIFO_DEPTH`, 512: FIFO capacity in words.
- `USEDW_W`, 10: width of `fifo_wrusedw`.

Ports:
- `clk`, in, 1: single clock, the FIFO write clock.
- `rst`, in, 1: reset; asynchronous, active-high.
- `enable`, in, 1: level; permits new bursts.
- `frame_sync`, in, 1: one-cycle pulse; restart at `BASE_ADDR`.
- `fifo_wrusedw`, in, `USEDW_W`: FIFO write-side fill count.
- `fifo_full`, in, 1: FIFO `full_flag`.
- `fifo_wr_rst_done`, in, 1: FIFO write side out of reset.
- `rd_req`, out, 1: burst request to the SDRAM controller.
- `rd_addr`, out, `ADDR_W`: burst start address.
- `rd_len`, out, 9: burst length in words, 1..256.
- `rd_ack`, in, 1: controller accepted the request.
- `rd_data_valid`, in, 1: a returned word is on the data bus this cycle.
- `rd_done`, in, 1: last word of the burst returned.
- `fifo_we`, out, 1: FIFO write enable; FIFO `di` is wired directly from SDRAM read data.
- `busy`, out, 1: state is not IDLE.
- `frame_done`, out, 1: one-cycle pulse when the last burst of a frame completes.
- `ovf_err`, out, 1: sticky; `fifo_we` was asserted while `fifo_full` was high.

## Operation
- **States:** IDLE, CHECK, REQ, XFER.
- **IDLE → CHECK:** when `enable && fifo_wr_rst_done`.
- **CHECK → REQ:** when `fifo_wrusedw + rd_len ≤ FIFO_DEPTH - 2`. The sum is computed `USEDW_W+1` bits wide.
- **CHECK → IDLE:** when `!enable`.
- **REQ:** `rd_req` is high. Leave REQ on `rd_ack`, same cycle, going to XFER.
- **XFER:** `fifo_we = rd_data_valid && !drop`. A 9-bit word counter increments on each `rd_data_valid`. On `rd_done`, go to CHECK.
- **Address bookkeeping:** `remain` is a down-counter initialised to `FRAME_WORDS`. `rd_len = min(BURST_LEN, remain)`. Both `rd_addr` and `remain` update on `rd_done`:
  - `rd_addr += rd_len`, `remain -= rd_len`.
  - If `remain` reaches 0: pulse `frame_done`, reset `rd_addr` to `BASE_ADDR` and `remain` to `FRAME_WORDS` in the same update.
- **`frame_sync` in IDLE, CHECK or REQ before ack:** pointer resets to `BASE_ADDR` / `FRAME_WORDS` immediately. A pending `rd_req` is re-presented with the new address.
- **`frame_sync` in XFER:** set `drop`. Remaining words of the current burst are not written. On `rd_done`, reset the pointer instead of advancing it and clear `drop`. No `frame_done` pulse.
- **`enable` deasserted mid-REQ or mid-XFER:** the burst completes normally, then the FSM returns to IDLE from CHECK.
- **`fifo_wr_rst_done` low:** forces IDLE. Any in-flight burst is finished first, with `drop` set.
- **`ovf_err`:** cleared only by `rst`.

## Timing
- **Reset values:** state IDLE; `rd_req` 0; `rd_addr` = `BASE_ADDR`; `rd_len` = `min(BURST_LEN, FRAME_WORDS)`; `fifo_we` 0; `busy` 0; `frame_done` 0; `ovf_err` 0; `drop` 0.
- **Request latency:** the CHECK condition is true in cycle n; `rd_req` is registered high in cycle n+1.
- **Request stability:** `rd_addr` and `rd_len` are stable while `rd_req` is high.
- **Handshake:** `rd_req` drops the cycle after `rd_ack` is sampled.
- **Write path:** `fifo_we` is combinational from `rd_data_valid` (zero latency), so data and enable reach the FIFO in the same cycle.
- **Outstanding bursts:** at most one. The next CHECK occurs the cycle after `rd_done`.
- **Why the −2 margin:** it absorbs the FIFO's write-side count latency. With one burst outstanding, overflow cannot occur with a compliant FIFO.

## Structure
- **Package `sdram_rd_pkg`:** state enum, the `rd_len` width constant (9), and a `min_len` function.
- **Single sub-module `sdram_addr_walker`:** owns `rd_addr`, `remain`, `rd_len`, the wrap and `frame_done`, with `advance` and `restart` inputs. The FSM stays in the top module.

## Test plan
- **Basic refill:** `FRAME_WORDS`=1024, `BURST_LEN`=256, `fifo_wrusedw`=0, `enable`=1 → four bursts at addresses 0, 256, 512, 768, each `rd_len`=256. `frame_done` pulses once after the 4th `rd_done`, then the next `rd_addr`=0.
- **Short tail burst:** `FRAME_WORDS`=600 → bursts of 256, 256, 88, at addresses 0, 256, 512. Then wrap to 0.
- **Backpressure:** `fifo_wrusedw`=255 → no `rd_req`. Change to 254 → `rd_req` one cycle later (254+256 = 510 = `FIFO_DEPTH`-2).
- **`frame_sync` mid-XFER after 100 words:** `fifo_we` count for that burst = 100. The next `rd_addr` = `BASE_ADDR`, and no `frame_done` pulse.
- **Reset mid-REQ:** assert `rst` while `rd_req`=1 → all outputs take their reset values asynchronously. After release, the first request is at `BASE_ADDR`.
- **Overflow error:** force `fifo_full`=1 while `rd_data_valid`=1 → `ovf_err`=1, and it stays 1 until `rst`.
